// File: rtl/obi_mem_responder_pkg.sv
// Shared definitions for the OBI memory responder.
//   OBI_ADDR_W / OBI_DATA_W : A-channel address and data widths.
//   obi_resp_entry_t        : one queued R-channel response (read data + error).
//   LFSR_SEED / LFSR_TAPS   : random-grant LFSR (taps 8,6,5,4) used when
//                             OBI_MEM_RESPONDER_RAND_STALL_EN is defined.
package obi_mem_responder_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 in 1-based LFSR notation map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_resp_entry_t;

  function automatic logic lfsr_feedback(input logic [7:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI A-channel and R-channel signals between an initiator (master) and the
// memory responder (slave). Signal names keep the responder-side affixes.
//   req_i/gnt_o             : A-channel handshake
//   addr_i/we_i/be_i/wdata_i : address phase
//   rvalid_o/rdata_o/err_o  : R-channel response (no rready)
interface obi_mem_responder_if;
  import obi_mem_responder_pkg::*;

  logic                  req_i;
  logic                  gnt_o;
  logic [OBI_ADDR_W-1:0] addr_i;
  logic                  we_i;
  logic [3:0]            be_i;
  logic [OBI_DATA_W-1:0] wdata_i;
  logic                  rvalid_o;
  logic [OBI_DATA_W-1:0] rdata_o;
  logic                  err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/obi_mem_responder_fifo.sv
// In-order response FIFO with a per-entry age counter.
//   push/push_data : enqueue an entry (caller guarantees !full)
//   pop            : dequeue the head (caller guarantees head_ready)
//   head           : head entry
//   full/empty     : occupancy flags
//   head_ready     : head entry has aged LAT cycles and may pop
//   count          : current occupancy
module obi_mem_responder_fifo #(
  parameter int  DEPTH   = 2,
  parameter int  LAT     = 0,
  parameter type entry_t = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic                       head_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           slots [DEPTH];
  logic [AGE_W-1:0] age   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!push && pop) cnt <= cnt - CNT_W'(1);
    end
  end

  // Ages of unoccupied slots are don't-care; validity comes from cnt.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wr_ptr == PTR_W'(i))  age[i] <= '0;
      else if (age[i] != AGE_W'(LAT))   age[i] <= age[i] + AGE_W'(1);
    end
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head       = slots[rd_ptr];
  assign full       = (cnt == CNT_W'(DEPTH));
  assign empty      = (cnt == '0);
  assign head_ready = !empty && (age[rd_ptr] == AGE_W'(LAT));
  assign count      = cnt;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory responder: grants A-channel requests after a configurable stall,
// reads/writes a word-addressed array and returns in-order R-channel
// responses RESP_LAT+1 cycles after accept, with up to OUTSTND in flight.
//   clk_i, rst_i : clock, synchronous active-high reset (also clears memory)
//   bus          : OBI slave modport (req/gnt/addr/we/be/wdata, rvalid/rdata/err)
//   outstnd_o    : response FIFO occupancy
// Optional macro OBI_MEM_RESPONDER_RAND_STALL_EN adds an LFSR-gated grant with
// a forced grant after 8 consecutive LFSR-blocked cycles.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int OUTSTND   = 2,
  parameter int GNT_STALL = 0,
  parameter int RESP_LAT  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  obi_mem_responder_if.slave           bus,
  output logic [$clog2(OUTSTND+1)-1:0] outstnd_o
);

  localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int STALL_W = (GNT_STALL > 0) ? $clog2(GNT_STALL + 1) : 1;

  logic [OBI_DATA_W-1:0] mem [MEM_WORDS];
  logic [STALL_W-1:0]    stall_cnt;
  logic [OBI_ADDR_W-3:0] idx;
  logic [IDX_W-1:0]      widx;
  logic                  in_range;
  logic                  stall_ok;
  logic                  lfsr_ok;
  logic                  accept;
  obi_resp_entry_t       push_entry;
  obi_resp_entry_t       head;
  logic                  full;
  logic                  empty;
  logic                  head_ready;

  assign idx      = bus.addr_i[OBI_ADDR_W-1:2];
  assign widx     = idx[IDX_W-1:0];
  assign in_range = ({2'b00, idx} < OBI_ADDR_W'(MEM_WORDS));
  assign stall_ok = (stall_cnt == STALL_W'(GNT_STALL));

`ifdef OBI_MEM_RESPONDER_RAND_STALL_EN
  logic [7:0] lfsr;
  logic [3:0] blk_cnt;

  assign lfsr_ok = lfsr[0] || (blk_cnt == 4'd8);

  // blk_cnt only counts cycles where the LFSR alone withheld the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr    <= LFSR_SEED;
      blk_cnt <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_feedback(lfsr)};
      if (!bus.req_i || bus.gnt_o)
        blk_cnt <= '0;
      else if (stall_ok && !full && !lfsr[0] && blk_cnt != 4'd8)
        blk_cnt <= blk_cnt + 4'd1;
    end
  end
`else
  assign lfsr_ok = 1'b1;
`endif

  // Full blocks the grant even when the head pops this cycle.
  assign bus.gnt_o = !rst_i && bus.req_i && stall_ok && !full && lfsr_ok;
  assign accept    = bus.req_i && bus.gnt_o;

  always_ff @(posedge clk_i) begin
    if (rst_i)                            stall_cnt <= '0;
    else if (!bus.req_i || bus.gnt_o)     stall_cnt <= '0;
    else if (!stall_ok)                   stall_cnt <= stall_cnt + STALL_W'(1);
  end

  // Read data comes from the pre-edge array, so it never sees a same-edge write.
  always_comb begin
    push_entry = '0;
    if (!in_range)      push_entry.err   = 1'b1;
    else if (!bus.we_i) push_entry.rdata = mem[widx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (accept && bus.we_i && in_range) begin
      for (int b = 0; b < 4; b++)
        if (bus.be_i[b]) mem[widx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
    end
  end

  obi_mem_responder_fifo #(
    .DEPTH   (OUTSTND),
    .LAT     (RESP_LAT),
    .entry_t (obi_resp_entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (accept),
    .push_data  (push_entry),
    .pop        (head_ready),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .head_ready (head_ready),
    .count      (outstnd_o)
  );

  // R-channel output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rvalid_o <= 1'b0;
      bus.rdata_o  <= '0;
      bus.err_o    <= 1'b0;
    end else begin
      bus.rvalid_o <= head_ready;
      bus.rdata_o  <= head_ready ? head.rdata : '0;
      bus.err_o    <= head_ready && head.err;
    end
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.req_i && !bus.gnt_o) |=> (bus.req_i && $stable(bus.addr_i) &&
      $stable(bus.we_i) && $stable(bus.be_i) && $stable(bus.wdata_i)));

  a_outstnd_bound: assert property (@(posedge clk_i) outstnd_o <= OUTSTND);

  a_pop_nonempty: assert property (@(posedge clk_i) head_ready |-> !empty);

endmodule

// File: tb/tb_obi_mem_responder.sv
// Self-checking bench for obi_mem_responder (default build). A queue-based
// reference model predicts grants, occupancy and responses each cycle from
// request-hold time, FIFO occupancy and per-response ready times.
module tb_obi_mem_responder;
  import obi_mem_responder_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int OUTSTND   = 2;
  localparam int GNT_STALL = 1;
  localparam int RESP_LAT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obi_mem_responder_if bus ();
  logic [$clog2(OUTSTND+1)-1:0] outstnd;

  obi_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .OUTSTND   (OUTSTND),
    .GNT_STALL (GNT_STALL),
    .RESP_LAT  (RESP_LAT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .outstnd_o (outstnd)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ready;   // first cycle in which this response may pop
  } resp_t;

  resp_t       q[$];
  logic [31:0] ref_mem [MEM_WORDS];
  int          cyc, hold;
  logic        exp_rv, exp_err, seen_gnt;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_resp, gnt_cyc, resp_cyc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  // Compare one cycle at the falling edge, advance the model, step past the edge.
  task automatic tick();
    logic        exp_gnt, pop;
    logic [29:0] widx;
    resp_t       e, h;
    @(negedge clk);
    seen_gnt = bus.gnt_o;
    if (rst) begin
      chk("gnt_in_reset", bus.gnt_o, 1'b0);
      q.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
      hold = 0; exp_rv = 0; exp_rdata = '0; exp_err = 0;
    end else begin
      exp_gnt = bus.req_i && (hold >= GNT_STALL) && (q.size() < OUTSTND);
      chk("gnt", bus.gnt_o, exp_gnt);
      chk("outstnd", outstnd, q.size());
      chk("rvalid", bus.rvalid_o, exp_rv);
      chk("rdata", bus.rdata_o, exp_rdata);
      chk("err", bus.err_o, exp_err);
      if (bus.rvalid_o) begin
        last_rdata = bus.rdata_o; last_err = bus.err_o; n_resp++; resp_cyc = cyc;
      end
      if (bus.gnt_o) gnt_cyc = cyc;
      pop = (q.size() > 0) && (q[0].ready <= cyc);
      exp_rv = 0; exp_rdata = '0; exp_err = 0;
      if (pop) begin
        h = q.pop_front();
        exp_rv = 1; exp_rdata = h.rdata; exp_err = h.err;
      end
      if (exp_gnt) begin
        widx = bus.addr_i[31:2];
        e.rdata = '0; e.err = 0; e.ready = cyc + 1 + RESP_LAT;
        if (widx >= MEM_WORDS) e.err = 1;
        else if (!bus.we_i) e.rdata = ref_mem[widx];
        else for (int b = 0; b < 4; b++)
          if (bus.be_i[b]) ref_mem[widx][8*b +: 8] = bus.wdata_i[8*b +: 8];
        q.push_back(e);
      end
      if (!bus.req_i || exp_gnt) hold = 0;
      else if (hold < GNT_STALL) hold++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output int waited);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.be_i = be; bus.wdata_i = wdata;
    waited = 0;
    forever begin
      tick();
      if (seen_gnt) break;
      waited++;
      if (waited > 64) begin
        chk("gnt_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.req_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    bus.req_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int w, w3, n_before;
    logic [29:0] ridx;
    bus.req_i = 0; bus.we_i = 0; bus.addr_i = '0; bus.be_i = '0; bus.wdata_i = '0;
    cyc = 0; hold = 0; exp_rv = 0; exp_rdata = '0; exp_err = 0;
    n_resp = 0; last_rdata = '0; last_err = 0; gnt_cyc = 0; resp_cyc = 0;

    do_reset();
    idle(2);

    // Write then read back; grant waits exactly GNT_STALL cycles from idle.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
    chk("stall_wait", w, GNT_STALL);
    idle(RESP_LAT + 3);
    issue(1'b0, 32'h10, 4'hF, 32'h0, w);
    chk("stall_wait_rd", w, GNT_STALL);
    idle(RESP_LAT + 3);
    chk("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    chk("rd_err0", last_err, 1'b0);
    chk("accept_to_rvalid", resp_cyc - gnt_cyc - 1, 1 + RESP_LAT);

    // Byte enables
    issue(1'b1, 32'h20, 4'hF, 32'hAABBCCDD, w);
    issue(1'b1, 32'h20, 4'b0101, 32'h11223344, w);
    issue(1'b1, 32'h20, 4'b0000, 32'h55555555, w);
    issue(1'b0, 32'h20, 4'hF, 32'h0, w);
    idle(RESP_LAT + 4);
    chk("byte_en", last_rdata, 32'hAA22CC44);

    // Out of range: error response, and no aliasing onto word 0.
    issue(1'b1, 32'h0, 4'hF, 32'h12345678, w);
    issue(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, w);
    issue(1'b0, 32'h400, 4'hF, 32'h0, w);
    idle(RESP_LAT + 4);
    chk("oor_err", last_err, 1'b1);
    chk("oor_rdata", last_rdata, 32'h0);
    issue(1'b0, 32'h0, 4'hF, 32'h0, w);
    idle(RESP_LAT + 4);
    chk("oor_no_write", last_rdata, 32'h12345678);

    // Backpressure: with GNT_STALL=1, RESP_LAT=4 the third back-to-back read
    // is held off by a full FIFO (including the cycle the head pops) and is
    // granted on its 4th request cycle.
    issue(1'b0, 32'h10, 4'hF, 32'h0, w);
    issue(1'b0, 32'h20, 4'hF, 32'h0, w);
    issue(1'b0, 32'h0, 4'hF, 32'h0, w3);
    chk("bp_wait", w3, 3);
    idle(3 * RESP_LAT);
    chk("bp_last", last_rdata, 32'h12345678);

    // Reset with two responses pending.
    issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, w);
    idle(RESP_LAT + 3);
    issue(1'b0, 32'h40, 4'hF, 32'h0, w);
    issue(1'b0, 32'h40, 4'hF, 32'h0, w);
    chk("pending_before_rst", outstnd, 2);
    n_before = n_resp;
    do_reset();
    idle(RESP_LAT + 6);
    chk("no_resp_after_rst", n_resp, n_before);
    issue(1'b0, 32'h40, 4'hF, 32'h0, w);
    idle(RESP_LAT + 3);
    chk("mem_cleared", last_rdata, 32'h0);

    // Randomized traffic on a small hot set plus boundary and out-of-range words.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else begin
        case ($urandom_range(0, 9))
          0:       ridx = 30'(MEM_WORDS + $urandom_range(0, 300));
          1:       ridx = 30'(MEM_WORDS - 1);
          default: ridx = 30'($urandom_range(0, 15));
        endcase
        issue(1'($urandom_range(0, 1)), {ridx, 2'($urandom_range(0, 3))},
              4'($urandom), $urandom, w);
      end
    end
    idle(3 * RESP_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obi_mem_responder.md
Name: obi_mem_responder

Overview:
- Synthesizable OBI data/instruction memory responder, the subordinate end of the core's OBI initiator ports.
- Used as the memory model in formal and simulation harnesses around cv32e40x_wrapper.
- Grants A-channel requests with a bounded, configurable stall and performs reads and writes on a small word-addressed array.
- Returns in-order R-channel responses after a configurable latency, with up to OUTSTND transactions in flight.

Parameters:
- MEM_WORDS, 256: number of 32-bit words in the backing array; the valid word index range is 0..MEM_WORDS-1.
- OUTSTND, 2: response FIFO depth, i.e. the maximum number of accepted transactions without a response (must be >= 1).
- GNT_STALL, 0: number of cycles req_i must be held before gnt_o may assert (0 = same-cycle grant).
- RESP_LAT, 0: extra cycles added to the 1-cycle minimum between accept and rvalid_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  A-channel request.
- gnt_o  out  1  A-channel grant; combinational from req_i and internal state.
- addr_i  in  32  byte address; bits [1:0] are ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  R-channel valid, registered, pulses one cycle per response.
- rdata_o  out  32  read data, registered.
- err_o  out  1  bus error, registered.
- outstnd_o  out  $clog2(OUTSTND+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_i high at a rising edge):
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outstnd_o=0.
  - FIFO emptied, stall counter cleared, memory cleared to 0.
  - Any in-flight responses are dropped and never returned.
- Stall counter:
  - Counts cycles with req_i=1 and no grant, saturating at GNT_STALL.
  - Clears on a grant, and clears when req_i=0.
- gnt_o = req_i && (stall_cnt == GNT_STALL) && (FIFO not full).
  - A full FIFO blocks the grant even if a pop occurs in the same cycle.
- Accept: req_i && gnt_o at a rising edge. Let idx = addr_i[31:2]; the request is in range when idx < MEM_WORDS.
  - Read, in range: push {rdata=mem[idx], err=0}.
  - Write, in range: for each lane b with be_i[b]=1, update mem[idx] byte b with wdata_i byte b; push {rdata=0, err=0}. be_i=0000 is legal and leaves memory unchanged.
  - Out of range (read or write): no memory change; push {rdata=0, err=1}.
  - Read data is sampled before any same-edge write, so a read always returns pre-write contents.
- Response timing:
  - Each FIFO entry carries an age counter that starts at 0 on push, increments each cycle, and saturates at RESP_LAT.
  - The head entry pops when its age == RESP_LAT; the pop registers rvalid_o=1 with its rdata/err on the following edge.
  - Accept-to-rvalid latency is therefore exactly 1+RESP_LAT cycles when the FIFO is otherwise idle.
  - At most one pop per cycle; responses are strictly in order.
- Simultaneous push and pop: occupancy is unchanged; a push into an empty FIFO cannot pop in the same cycle.
- Outside pops: rvalid_o=0; rdata_o and err_o are forced to 0.
- There is no rready; the core must always accept responses.
- Protocol expectations, checked by assertion:
  - Once req_i rises, req_i and the address phase signals stay stable until the grant.
  - outstnd_o <= OUTSTND at all times.

Optional Feature:
- Macro: OBI_MEM_RESPONDER_RAND_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle) gates the grant.
  - gnt_o additionally requires lfsr[0]=1, on top of the GNT_STALL condition.
  - A forced grant occurs after 8 consecutive LFSR-blocked cycles of a held req_i, bounding liveness for formal.
- Undefined: no LFSR logic is present; the grant is fully deterministic as specified above.

Decomposition:
- Shared package obi_mem_responder_pkg:
  - OBI_ADDR_W=32 and OBI_DATA_W=32.
  - Typedef obi_resp_entry_t {logic [31:0] rdata; logic err;}.
  - LFSR seed and taps constants.
- Sub-module obi_mem_responder_fifo:
  - Parameterised by depth and entry type.
  - Holds entries plus per-entry age counters.
  - Exposes push, pop, full, empty, head_ready and count.

Test Plan:
- Read latency: after reset, write 32'hDEADBEEF to addr 0x10 with be=1111, then read 0x10 with GNT_STALL=0, RESP_LAT=0 -> gnt in the request cycle, rvalid one cycle after accept, rdata=32'hDEADBEEF, err=0.
- Byte enables: write 32'h11223344 with be=0101 over 32'hAABBCCDD at 0x20 -> a subsequent read returns 32'hAA22CC44.
- Out of range: with MEM_WORDS=256, read addr 0x400 -> rvalid with err=1, rdata=0; a write to 0x400 changes no word in memory.
- Backpressure: OUTSTND=2, RESP_LAT=3, req held for 3 back-to-back reads -> first two granted, gnt_o=0 until the first pop; outstnd_o sequence 1,2,2, responses returned in order.
- Grant stall: GNT_STALL=2, req held -> gnt_o asserts exactly in the 3rd cycle of req; dropping req after 1 cycle resets the count.
- Reset mid-operation: rst_i pulsed while 2 responses are pending -> no rvalid afterwards, outstnd_o=0, and a read of a previously written address returns 0.
